l15_tag_lookup_ctrl: RTL



---
 rtl/l15_tag_pkg.sv | 26 ++
 rtl/l15_tag_lookup_ctrl_cmp.sv | 28 ++
 rtl/l15_tag_lookup_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/l15_tag_pkg.sv
// Shared types and helpers for the L1.5 instruction-cache tag lookup slice.
// Optional macro: L15_TAG_PARITY_EN adds an even-parity bit above {valid, tag}.
package l15_tag_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    INIT_SWEEP  = 2'd1,
    FLUSH_SWEEP = 2'd2
  } state_t;

  localparam int DEFAULT_SET_ADDR_WIDTH = 6;
  localparam int DEFAULT_TAG_WIDTH      = 6;

  // Position of the valid bit for the default tag width (entry = {valid, tag}).
  localparam int VALID_BIT = DEFAULT_TAG_WIDTH;

  // Width of one stored tag entry: {valid, tag}, plus a parity MSB when enabled.
  function automatic int tag_entry_width(input int tag_width);
`ifdef L15_TAG_PARITY_EN
    return tag_width + 2;
`else
    return tag_width + 1;
`endif
  endfunction

endpackage

// File: rtl/l15_tag_lookup_ctrl_cmp.sv
// Combinational tag comparator for one way: valid check, tag equality and,
// when L15_TAG_PARITY_EN is defined, an even-parity check over the whole word.
module l15_tag_cmp
  import l15_tag_pkg::*;
#(
  parameter int TAG_WIDTH = 6
) (
  input  logic [tag_entry_width(TAG_WIDTH)-1:0] rdata,
  input  logic [TAG_WIDTH-1:0]                  cmp_tag,
`ifdef L15_TAG_PARITY_EN
  output logic                                  parity_err,
`endif
  output logic                                  hit
);

  logic tag_match;

  assign tag_match = rdata[TAG_WIDTH] & (rdata[TAG_WIDTH-1:0] == cmp_tag);

`ifdef L15_TAG_PARITY_EN
  // A stored word with odd total parity is corrupt and can never hit.
  assign parity_err = ^rdata;
  assign hit        = tag_match & ~parity_err;
`else
  assign hit        = tag_match;
`endif

endmodule

// File: rtl/l15_tag_lookup_ctrl.sv
// L1.5 I-cache tag-RAM port controller: invalidation sweeps, refill writes
// and fetch lookups share one tag-RAM port; lookups return hit one cycle
// after grant. Optional macro: L15_TAG_PARITY_EN (parity bit + parity_err).
module l15_tag_lookup_ctrl
  import l15_tag_pkg::*;
#(
  parameter int SET_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH      = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  lookup_req,
  output logic                                  lookup_gnt,
  input  logic [SET_ADDR_WIDTH-1:0]             lookup_set,
  input  logic [TAG_WIDTH-1:0]                  lookup_tag,
  output logic                                  lookup_rvalid,
  output logic                                  lookup_hit,
  input  logic                                  refill_req,
  input  logic [SET_ADDR_WIDTH-1:0]             refill_set,
  input  logic [TAG_WIDTH-1:0]                  refill_tag,
  output logic                                  refill_gnt,
  input  logic                                  flush_req,
  output logic                                  flush_ack,
  output logic                                  busy,
  output logic                                  tag_req,
  output logic                                  tag_write,
  output logic [SET_ADDR_WIDTH-1:0]             tag_addr,
  output logic [tag_entry_width(TAG_WIDTH)-1:0] tag_wdata,
`ifdef L15_TAG_PARITY_EN
  output logic                                  parity_err,
`endif
  input  logic [tag_entry_width(TAG_WIDTH)-1:0] tag_rdata
);

  localparam logic [SET_ADDR_WIDTH-1:0] LAST_SET = {SET_ADDR_WIDTH{1'b1}};

  state_t                    state;
  logic [SET_ADDR_WIDTH-1:0] sweep_cnt;
  logic [TAG_WIDTH-1:0]      cmp_tag;
  logic [TAG_WIDTH:0]        refill_entry;
  logic                      cmp_hit;

  assign busy         = (state != IDLE);
  assign refill_entry = {1'b1, refill_tag};

  // Sweep sequencing: count through every set, return to IDLE after the last,
  // and acknowledge only sweeps that were requested by flush_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_SWEEP;
      sweep_cnt <= '0;
      flush_ack <= 1'b0;
    end else begin
      flush_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req && !flush_ack) begin
            state     <= FLUSH_SWEEP;
            sweep_cnt <= '0;
          end
        end
        INIT_SWEEP, FLUSH_SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_SET) begin
            state     <= IDLE;
            flush_ack <= (state == FLUSH_SWEEP);
          end
        end
        default: begin
          state     <= INIT_SWEEP;
          sweep_cnt <= '0;
        end
      endcase
    end
  end

  // Port arbitration: sweep owns the port, otherwise refill beats lookup.
  always_comb begin
    tag_req    = 1'b0;
    tag_write  = 1'b0;
    tag_addr   = '0;
    tag_wdata  = '0;
    refill_gnt = 1'b0;
    lookup_gnt = 1'b0;
    if (busy) begin
      tag_req   = 1'b1;
      tag_write = 1'b1;
      tag_addr  = sweep_cnt;
    end else if (refill_req) begin
      tag_req    = 1'b1;
      tag_write  = 1'b1;
      tag_addr   = refill_set;
      refill_gnt = 1'b1;
`ifdef L15_TAG_PARITY_EN
      tag_wdata  = {^refill_entry, refill_entry};
`else
      tag_wdata  = refill_entry;
`endif
    end else if (lookup_req) begin
      tag_req    = 1'b1;
      lookup_gnt = 1'b1;
      tag_addr   = lookup_set;
    end
  end

  // Lookup result stage: capture the request tag to compare with next-cycle data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_rvalid <= 1'b0;
      cmp_tag       <= '0;
    end else begin
      lookup_rvalid <= lookup_gnt;
      if (lookup_gnt) begin
        cmp_tag <= lookup_tag;
      end
    end
  end

`ifdef L15_TAG_PARITY_EN
  logic cmp_perr;

  l15_tag_cmp #(.TAG_WIDTH(TAG_WIDTH)) u_cmp (
    .rdata      (tag_rdata),
    .cmp_tag    (cmp_tag),
    .parity_err (cmp_perr),
    .hit        (cmp_hit)
  );

  assign parity_err = lookup_rvalid & cmp_perr;
`else
  l15_tag_cmp #(.TAG_WIDTH(TAG_WIDTH)) u_cmp (
    .rdata   (tag_rdata),
    .cmp_tag (cmp_tag),
    .hit     (cmp_hit)
  );
`endif

  assign lookup_hit = lookup_rvalid & cmp_hit;

endmodule
